moore_det_sched: RTL and testbench
==================================

// Module: moore_det_sched
// PURPOSE
//   Round-robin scheduler that shares one Moore serial sequence detector between NREQ requesters.
//   - Accepts one W-bit word per job and shifts it MSB-first into the detector.
//   - Counts the overlapping occurrences of PATTERN in the word.
//   - Returns the count and the requester id on a valid/ready response channel.
//   - Sits between the word producers and the single shared detector resource.
// PARAMETERS
//   NREQ     4        number of requesters (>=2)
//   W        8        word width in bits, shifted MSB first (W >= PLEN)
//   PLEN     4        pattern length in bits (1..W)
//   PATTERN  4'b1011  pattern to detect; first-received bit is PATTERN[PLEN-1]
// PORTS
//   clk        in   1                  rising-edge clock
//   reset_n    in   1                  asynchronous active-low reset
//   req_valid  in   NREQ               per-requester job request
//   req_data   in   NREQ*W             word of requester i in bits [i*W +: W]
//   req_ready  out  NREQ               one-hot accept strobe (combinational)
//   rsp_valid  out  1                  result available
//   rsp_id     out  $clog2(NREQ)       requester index of the result
//   rsp_count  out  $clog2(W+1)        number of pattern matches
//   rsp_ready  in   1                  consumer accepts the result
//   rsp_pos    out  $clog2(W)          only when FIRST_POS_EN is defined
// BEHAVIOUR
//   Clock and reset
//   - One clock, clk; reset_n is asynchronous, active-low.
//   - Reset forces: FSM=IDLE; rsp_valid=0; rsp_id=0; rsp_count=0; rsp_pos=0;
//     req_ready=0; rr pointer=0; detector cleared.
//   - Reset mid-job drops the in-flight job with no response; that requester must re-request.
//   FSM states: IDLE, SHIFT, FLUSH, DONE
//   - IDLE, any req_valid:
//     - grant = first valid index at or after (last_grant+1) mod NREQ; after reset, index 0 has top priority.
//     - req_ready[grant]=1 for this cycle only.
//     - Capture word into the shift register, clear the detector and the bit counter, go to SHIFT.
//     - IDLE with no req_valid: stay in IDLE.
//   - SHIFT, cycles 1..W: X = shreg MSB; shift left each cycle; after W bits go to FLUSH.
//   - FLUSH, cycle W+1: absorbs the one-cycle Moore output lag; go to DONE.
//   - DONE, cycle W+2 onward: rsp_valid=1, outputs held stable; leave for IDLE on the cycle rsp_valid&&rsp_ready.
//   Counting and timing
//   - Count increments on every cycle where detector Z=1 while in SHIFT or FLUSH.
//   - Z is a function of detector state only, so it reflects the bit applied the previous cycle.
//   - Count saturates structurally: at most W-PLEN+1 matches, which the count width holds.
//   - Overlapping matches count; no match spans two jobs, because the detector is cleared at accept.
//   - Latency: accept to rsp_valid = W+2 cycles.
//   - Back-to-back jobs take W+3 cycles each; no accept in DONE, even when rsp_ready is high.
//   Requester rules
//   - A requester holds req_valid and req_data stable until it sees req_ready; a dropped request is not an error.
//   - req_valid changes outside IDLE are ignored.
//   - Non-granted valid requesters wait; the grant is never preempted.
//   - An arriving req_valid while busy is served in fairness order at the next IDLE.
// CONFIGURATION
//   FIRST_POS_EN defined
//   - rsp_pos port exists: bit index (0 = first-shifted MSB) of the last bit of the first match.
//   - rsp_pos=0 when rsp_count=0.
//   - Captured on the first Z=1 of the job, held through DONE.
//   FIRST_POS_EN undefined
//   - rsp_pos port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package moore_det_pkg
//   - typedef sched_state_t {IDLE,SHIFT,FLUSH,DONE}.
//   - localparam widths: ID_W=$clog2(NREQ), CNT_W=$clog2(W+1), POS_W=$clog2(W).
//   Sub-module seq_det_moore
//   - ports: clk, reset_n, clr, en, x, z.
//   - State = last PLEN received bits plus a fill count.
//   - z = (fill>=PLEN) && (window==PATTERN), with z=0 after clr.
//   Top-level contents: round-robin grant, shift register, bit counter, result registers.
// TESTING  (NREQ=4, W=8, PLEN=4, PATTERN=4'b1011)
//   1. Reset, then req_valid=0001, data0=8'b1011_0110
//      -> req_ready=0001 for one cycle; rsp_valid at +10 cycles; rsp_id=0; rsp_count=2; rsp_pos=3.
//   2. Single request, data=8'hFF
//      -> rsp_count=0, rsp_pos=0.
//   3. Single request, data=8'b1011_1011
//      -> rsp_count=2 (ends at idx 3 and 7); no phantom match across jobs on the next job with 8'h00.
//   4. req_valid=1111 held, rsp_ready=1
//      -> grants in order 0,1,2,3,0; one accept every 11 cycles.
//   5. rsp_ready=0 for 5 cycles in DONE
//      -> rsp_valid and rsp fields stable; no req_ready pulses; accept resumes 1 cycle after the handshake.
//   6. reset_n low during SHIFT
//      -> all outputs 0 immediately; after release, grant restarts from requester 0 with no stale response.

Source files
------------

// File: rtl/moore_det_pkg.sv
// Shared types, default parameters and width helpers for the shared Moore detector scheduler.
// Optional feature macro: FIRST_POS_EN (adds rsp_pos on moore_det_sched).
package moore_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } sched_state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF = 8;
    localparam int PLEN_DEF = 4;
    localparam logic [PLEN_DEF-1:0] PATTERN_DEF = 4'b1011;

    localparam int ID_W = $clog2(NREQ_DEF);
    localparam int CNT_W = $clog2(W_DEF + 1);
    localparam int POS_W = $clog2(W_DEF);

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/moore_det_sched_det.sv
// Moore sequence detector: z depends only on the stored window and fill count.
// A clear empties the window so no match can span two jobs.
module seq_det_moore
    import moore_det_pkg::*;
#(
    parameter int              PLEN    = PLEN_DEF,
    parameter logic [PLEN-1:0] PATTERN = PATTERN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    localparam int FW = $clog2(PLEN + 1);

    logic [PLEN-1:0] r_win;
    logic [FW-1:0]   r_fill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_win <= PLEN'({r_win, x});
            if (r_fill != FW'(PLEN))
                r_fill <= r_fill + FW'(1);
        end
    end

    assign z = (r_fill >= FW'(PLEN)) && (r_win == PATTERN);

endmodule

// File: rtl/moore_det_sched.sv
// Round-robin scheduler sharing one Moore detector between NREQ requesters.
// Define FIRST_POS_EN to add rsp_pos (index of the last bit of the first match).
module moore_det_sched
    import moore_det_pkg::*;
#(
    parameter int              NREQ    = NREQ_DEF,
    parameter int              W       = W_DEF,
    parameter int              PLEN    = PLEN_DEF,
    parameter logic [PLEN-1:0] PATTERN = PATTERN_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [$clog2(W+1)-1:0]    rsp_count,
    input  logic                      rsp_ready
`ifdef FIRST_POS_EN
    ,
    output logic [$clog2(W)-1:0]      rsp_pos
`endif
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(W + 1);
`ifdef FIRST_POS_EN
    localparam int POSW = $clog2(W);
`endif

    sched_state_t    r_state;
    logic [W-1:0]    r_shreg;
    logic [CNTW-1:0] r_bitcnt;
    logic [IDW-1:0]  r_ptr;

    logic            w_any;
    logic [IDW-1:0]  w_grant;
    logic            w_accept;
    logic            w_z;
    logic            w_busy;
    logic [W-1:0]    w_word;
    int              w_j;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NREQ)
                w_j = w_j - NREQ;
            if (!w_any && req_valid[w_j]) begin
                w_any   = 1'b1;
                w_grant = IDW'(w_j);
            end
        end
    end

    assign w_accept  = reset_n && (r_state == IDLE) && w_any;
    assign req_ready = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant) : '0;
    assign w_word    = req_data[w_grant*W +: W];
    assign w_busy    = (r_state == SHIFT) || (r_state == FLUSH);

    seq_det_moore #(
        .PLEN    (PLEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_accept),
        .en      (r_state == SHIFT),
        .x       (r_shreg[W-1]),
        .z       (w_z)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_ptr     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
`ifdef FIRST_POS_EN
            rsp_pos   <= '0;
`endif
        end else begin
            // z lags the applied bit by one cycle, so FLUSH still counts.
            if (w_busy && w_z) begin
                rsp_count <= rsp_count + CNTW'(1);
`ifdef FIRST_POS_EN
                if (rsp_count == '0)
                    rsp_pos <= POSW'(r_bitcnt - CNTW'(1));
`endif
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_word;
                        r_bitcnt  <= '0;
                        rsp_id    <= w_grant;
                        rsp_count <= '0;
`ifdef FIRST_POS_EN
                        rsp_pos   <= '0;
`endif
                        r_ptr     <= IDW'(wrap_inc(int'(w_grant), NREQ));
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shreg  <= r_shreg << 1;
                    r_bitcnt <= r_bitcnt + CNTW'(1);
                    if (r_bitcnt == CNTW'(W - 1))
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    rsp_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_det_sched.sv
// Directed bench for moore_det_sched (NREQ=4, W=8, PLEN=4, PATTERN=1011).
module tb_moore_det_sched;
    import moore_det_pkg::*;

    logic                clk;
    logic                reset_n;
    logic [3:0]          req_valid;
    logic [31:0]         req_data;
    logic [3:0]          req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [CNT_W-1:0]    rsp_count;
    logic                rsp_ready;
`ifdef FIRST_POS_EN
    logic [POS_W-1:0]    rsp_pos;
`endif

    int checks = 0;
    int failures = 0;

    moore_det_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready)
`ifdef FIRST_POS_EN
        ,
        .rsp_pos   (rsp_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full job for a single requester; caller sits in an IDLE cycle.
    task automatic do_job(input string tag, input int id, input logic [7:0] d,
                          input int ecnt, input int epos);
        req_valid = 4'b0001 << id;
        req_data  = '0;
        req_data[id*8 +: 8] = d;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << id));
        cyc();
        req_valid = '0;
        chk({tag, ".ready_off"}, 32'(req_ready), 0);
        repeat (8) cyc();
        chk({tag, ".valid_early"}, 32'(rsp_valid), 0);
        cyc();
        chk({tag, ".valid"}, 32'(rsp_valid), 1);
        chk({tag, ".id"}, 32'(rsp_id), 32'(id));
        chk({tag, ".count"}, 32'(rsp_count), 32'(ecnt));
`ifdef FIRST_POS_EN
        chk({tag, ".pos"}, 32'(rsp_pos), 32'(epos));
`else
        if (epos < 0) $display("unused position %0d", epos);
`endif
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int ecnt [4];
        int epos [4];
        int exp_id;
        logic saw_ready;
        ecnt = '{2, 0, 2, 1};
        epos = '{3, 0, 3, 6};

        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst.valid", 32'(rsp_valid), 0);
        chk("rst.id", 32'(rsp_id), 0);
        chk("rst.count", 32'(rsp_count), 0);
        chk("rst.ready", 32'(req_ready), 0);
        cyc();
        cyc();
        reset_n = 1'b1;

        do_job("t1", 0, 8'b1011_0110, 2, 3);
        do_job("t2", 2, 8'hFF, 0, 0);
        do_job("t3a", 3, 8'b1011_1011, 2, 3);
        do_job("t3b", 1, 8'h00, 0, 0);

        // Fair rotation from a fresh reset with all requesters held valid.
        reset_n = 1'b0;
        cyc();
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        req_data  = {8'h16, 8'hBB, 8'hFF, 8'hB6};
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            #1;
            chk($sformatf("t4.grant%0d", k), 32'(req_ready),
                32'(4'b0001 << exp_id));
            saw_ready = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                cyc();
                if (req_ready != '0)
                    saw_ready = 1'b1;
            end
            chk($sformatf("t4.gap%0d", k), 32'(saw_ready), 0);
            chk($sformatf("t4.valid%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("t4.id%0d", k), 32'(rsp_id), 32'(exp_id));
            chk($sformatf("t4.count%0d", k), 32'(rsp_count),
                32'(ecnt[exp_id]));
`ifdef FIRST_POS_EN
            chk($sformatf("t4.pos%0d", k), 32'(rsp_pos),
                32'(epos[exp_id]));
`endif
            if (k == 4)
                req_valid = '0;
            cyc();
        end
        rsp_ready = 1'b0;
        #1;
        chk("t4.idle", 32'(req_ready), 0);

        // Backpressure in DONE, with a late arrival from requester 1.
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'hB6, 8'hFF, 8'h00};
        #1;
        chk("t5.grant", 32'(req_ready), 32'(4'b0100));
        cyc();
        req_valid = 4'b0010;
        repeat (9) cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5.valid%0d", i), 32'(rsp_valid), 1);
            chk($sformatf("t5.id%0d", i), 32'(rsp_id), 2);
            chk($sformatf("t5.count%0d", i), 32'(rsp_count), 2);
            chk($sformatf("t5.noready%0d", i), 32'(req_ready), 0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5.hs_valid", 32'(rsp_valid), 1);
        chk("t5.hs_noready", 32'(req_ready), 0);
        cyc();
        rsp_ready = 1'b0;
        chk("t5.after_valid", 32'(rsp_valid), 0);
        chk("t5.resume", 32'(req_ready), 32'(4'b0010));

        // Reset in the middle of requester 1's SHIFT phase.
        cyc();
        req_valid = '0;
        chk("t6.id_loaded", 32'(rsp_id), 1);
        cyc();
        cyc();
        req_valid = 4'b0010;
        reset_n   = 1'b0;
        #1;
        chk("t6.valid", 32'(rsp_valid), 0);
        chk("t6.ready", 32'(req_ready), 0);
        chk("t6.id", 32'(rsp_id), 0);
        chk("t6.count", 32'(rsp_count), 0);
`ifdef FIRST_POS_EN
        chk("t6.pos", 32'(rsp_pos), 0);
`endif
        cyc();
        req_valid = 4'b1111;
        req_data  = {8'h16, 8'hBB, 8'hFF, 8'hB6};
        reset_n   = 1'b1;
        #1;
        chk("t6.regrant", 32'(req_ready), 32'(4'b0001));
        cyc();
        req_valid = '0;
        repeat (8) cyc();
        chk("t6.no_stale", 32'(rsp_valid), 0);
        cyc();
        chk("t6.valid_new", 32'(rsp_valid), 1);
        chk("t6.id_new", 32'(rsp_id), 0);
        chk("t6.count_new", 32'(rsp_count), 2);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
